uart_tx_periph: RTL

Memory-mapped UART transmitter occupying the 0x3000_0000 slave slot of the system bus. It accepts CPU writes through the bus-decoded `uart_wen`/`uart_wdata` strobe and queues bytes in a small FIFO. It serialises the bytes as 8N1 frames on `uart_txd` and returns a status word on `uart_rdata` for CPU polling. It is the responder end of the bus's UART slave interface.

---
 rtl/uart_tx_periph_pkg.sv | 20 ++
 rtl/uart_tx_periph_fifo.sv | 56 +++++
 rtl/uart_tx_periph.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: status/control
// bit positions and TX state encodings.
package uart_tx_periph_pkg;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 8;

   localparam int CTL_CLR_OVF  = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// Synchronous FIFO with natural-wrap pointers and a separate occupancy count.
// Push while full and pop while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; the pointers and count alone
   // define which entries are valid, and this keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: write decode, sticky overflow flag,
// TX FIFO, baud counter and serialiser FSM, plus a pollable status word.
module uart_tx_periph #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_wen,
   input  logic [31:0] uart_wdata,
   output logic [31:0] uart_rdata,
   output logic        uart_txd
);

   import uart_tx_periph_pkg::*;

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);

   if (DIV < 2) begin : g_div_check
      $error("uart_tx_periph: CLK_FREQ/BAUD must be at least 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (1 << AW) != FIFO_DEPTH) begin : g_depth_check
      $error("uart_tx_periph: FIFO_DEPTH must be a power of two in 2..16");
   end

   tx_state_t     state;
   logic [7:0]    shift;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic          overflow;
   logic          txd_q;

   logic          push;
   logic          clr_ovf;
   logic          pop;
   logic          baud_wrap;
   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [AW:0]   fifo_count;
   logic          unused_wdata;

   assign push         = uart_wen & ~uart_wdata[CTL_CLR_OVF];
   assign clr_ovf      = uart_wen &  uart_wdata[CTL_CLR_OVF];
   assign pop          = (state == IDLE) & ~fifo_empty;
   assign baud_wrap    = (baud_cnt == CW'(DIV - 1));
   assign unused_wdata = ^uart_wdata[30:8];
   assign uart_txd     = txd_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (uart_wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Fullness is judged on pre-edge state, so a same-cycle pop does not rescue the byte.
   always_ff @(posedge clk) begin
      if (rst)                       overflow <= 1'b0;
      else if (clr_ovf)              overflow <= 1'b0;
      else if (push && fifo_full)    overflow <= 1'b1;
   end

   // Line level is registered from the current state, so it trails the FSM by one clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shift    <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         txd_q    <= 1'b1;
      end else begin
         unique case (state)
            START:   txd_q <= 1'b0;
            DATA:    txd_q <= shift[0];
            default: txd_q <= 1'b1;
         endcase

         unique case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  shift    <= fifo_dout;
                  baud_cnt <= '0;
                  state    <= START;
               end
            end
            START: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  if (bit_idx == 3'd7) state   <= STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // NOTE: the zero default written first keeps this block free of latches.
   always_comb begin
      uart_rdata                             = '0;
      uart_rdata[ST_BUSY]                    = (state != IDLE);
      uart_rdata[ST_FULL]                    = fifo_full;
      uart_rdata[ST_EMPTY]                   = fifo_empty;
      uart_rdata[ST_OVF]                     = overflow;
      uart_rdata[ST_COUNT_LSB +: (AW + 1)]   = fifo_count;
   end

endmodule
